iodelay_tap_seq: RTL and testbench

//  Sequencer that drives the per-channel IODELAY pulse shaper. On each command it

---
 rtl/iodelay_tap_seq_pkg.sv | 43 ++++
 rtl/iodelay_seq_timer.sv | 32 +++
 rtl/iodelay_tap_seq.sv | 204 ++++++++++++++++++++
 tb/tb_iodelay_tap_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/iodelay_tap_seq_pkg.sv
// Shared definitions for the IODELAY tap sequencer.
// Contents:
//   state_t      - 3-bit sequencer state encoding
//   DEF_HOLD     - default cycles a request level stays high
//   DEF_GAP      - default low cycles after each rst/inc request
//   DEF_CAL_WAIT - default low cycles after cal before rst
//   clog2, max3  - elaboration-time helpers for sizing the timer
package iodelay_seq_defs;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CAL_H = 3'd1,
    CAL_W = 3'd2,
    RST_H = 3'd3,
    RST_L = 3'd4,
    INC_H = 3'd5,
    INC_L = 3'd6,
    FIN   = 3'd7
  } state_t;

  localparam int unsigned DEF_HOLD     = 4;
  localparam int unsigned DEF_GAP      = 4;
  localparam int unsigned DEF_CAL_WAIT = 64;

  // Smallest r with 2**r >= v.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/iodelay_seq_timer.sv
// Down-counter that times every sequencer state.
// Ports:
//   clk      in  1  system clock
//   reset    in  1  asynchronous, active-high; clears the count
//   load     in  1  load load_val this cycle (state entry)
//   load_val in  W  cycles-minus-one for the state being entered
//   value    out W  current count
//   expire   out 1  count has reached 0; the owning state exits now
module iodelay_seq_timer #(
  parameter int unsigned W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         expire
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - W'(1);
    end
  end

  assign expire = (value == '0);

endmodule

// File: rtl/iodelay_tap_seq.sv
// Sequencer driving the per-channel IODELAY pulse shaper. Each accepted
// command calibrates the delay, resets it, then issues exactly tap increment
// requests. Requests are levels held HOLD cycles, separated by lows of at
// least GAP cycles, so the shaper sees one clean edge per request.
// Ports:
//   clk      in  1     system clock; all outputs registered on it
//   reset    in  1     asynchronous, active-high; clears all state
//   start    in  1     command strobe, sampled only in IDLE
//   tap      in  TAPW  target tap, latched when start is accepted
//   busy     out 1     high from the cycle after acceptance until done
//   done     out 1     one-cycle pulse at sequence completion
//   err      out 1     one-cycle pulse when start carries tap > MAX_TAP
//   cal_o    out 1     calibration request level
//   rst_o    out 1     delay-reset request level
//   pulse_o  out 1     increment request level
//   cur_tap  out TAPW  increments issued since the last rst
module iodelay_tap_seq
  import iodelay_seq_defs::*;
#(
  parameter int unsigned TAPW     = 5,
  parameter int unsigned MAX_TAP  = 31,
  parameter int unsigned HOLD     = DEF_HOLD,
  parameter int unsigned GAP      = DEF_GAP,
  parameter int unsigned CAL_WAIT = DEF_CAL_WAIT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [TAPW-1:0] tap,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            cal_o,
  output logic            rst_o,
  output logic            pulse_o,
  output logic [TAPW-1:0] cur_tap
);

  localparam int unsigned TMRW = clog2(max3(HOLD, GAP, CAL_WAIT) + 1);

  localparam logic [TMRW-1:0] LD_HOLD = TMRW'(HOLD - 1);
  localparam logic [TMRW-1:0] LD_GAP  = TMRW'(GAP - 1);
  localparam logic [TMRW-1:0] LD_CALW = TMRW'(CAL_WAIT - 1);

  state_t            state;
  state_t            state_nxt;
  logic [TAPW-1:0]   tap_q;
  logic              tap_ok;
  logic              accept;
  logic              reject;
  logic              cur_clr;
  logic              cur_inc;
  logic              tmr_load;
  logic [TMRW-1:0]   tmr_val;
  logic [TMRW-1:0]   tmr_value;
  logic              tmr_exp;
  logic              tmr_unused;

  iodelay_seq_timer #(
    .W(TMRW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .value    (tmr_value),
    .expire   (tmr_exp)
  );

  // The count itself is only observed through expire.
  assign tmr_unused = ^tmr_value;

  assign tap_ok = (32'(tap) <= MAX_TAP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    accept    = 1'b0;
    reject    = 1'b0;
    cur_clr   = 1'b0;
    cur_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (tap_ok) begin
            accept    = 1'b1;
            state_nxt = CAL_H;
            tmr_load  = 1'b1;
            tmr_val   = LD_HOLD;
          end else begin
            reject = 1'b1;
          end
        end
      end
      CAL_H: begin
        if (tmr_exp) begin
          state_nxt = CAL_W;
          tmr_load  = 1'b1;
          tmr_val   = LD_CALW;
        end
      end
      CAL_W: begin
        if (tmr_exp) begin
          state_nxt = RST_H;
          tmr_load  = 1'b1;
          tmr_val   = LD_HOLD;
          cur_clr   = 1'b1;
        end
      end
      RST_H: begin
        if (tmr_exp) begin
          state_nxt = RST_L;
          tmr_load  = 1'b1;
          tmr_val   = LD_GAP;
        end
      end
      RST_L: begin
        if (tmr_exp) begin
          if (tap_q != '0) begin
            state_nxt = INC_H;
            tmr_load  = 1'b1;
            tmr_val   = LD_HOLD;
          end else begin
            state_nxt = FIN;
          end
        end
      end
      INC_H: begin
        if (tmr_exp) begin
          state_nxt = INC_L;
          tmr_load  = 1'b1;
          tmr_val   = LD_GAP;
          cur_inc   = 1'b1;
        end
      end
      INC_L: begin
        if (tmr_exp) begin
          if (cur_tap != tap_q) begin
            state_nxt = INC_H;
            tmr_load  = 1'b1;
            tmr_val   = LD_HOLD;
          end else begin
            state_nxt = FIN;
          end
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Tap latch and increment counter. cur_tap never exceeds tap_q, which is
  // bounded by MAX_TAP, so the counter cannot wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tap_q   <= '0;
      cur_tap <= '0;
    end else begin
      if (accept) begin
        tap_q <= tap;
      end
      if (cur_clr) begin
        cur_tap <= '0;
      end else if (cur_inc) begin
        cur_tap <= cur_tap + TAPW'(1);
      end
    end
  end

  // Output levels are registered decodes of the current state, so they trail
  // the state register by one cycle; the documented done latency includes
  // that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      cal_o   <= 1'b0;
      rst_o   <= 1'b0;
      pulse_o <= 1'b0;
    end else begin
      busy    <= (state != IDLE) && (state != FIN);
      done    <= (state == FIN);
      err     <= reject;
      cal_o   <= (state == CAL_H);
      rst_o   <= (state == RST_H);
      pulse_o <= (state == INC_H);
    end
  end

endmodule

// File: tb/tb_iodelay_tap_seq.sv
module tb_iodelay_tap_seq;

  localparam int H    = 4;
  localparam int G    = 4;
  localparam int CW   = 64;
  localparam int MAXT = 31;
  localparam int TW   = 6;
  localparam int S0   = 2*H + CW + G + 1;   // first cycle pulse_o is high

  logic          clk;
  logic          reset;
  logic          start;
  logic [TW-1:0] tap;
  logic          busy;
  logic          done;
  logic          err;
  logic          cal_o;
  logic          rst_o;
  logic          pulse_o;
  logic [TW-1:0] cur_tap;

  int checks;
  int failures;

  // Reference model: a command accepted at edge E is described entirely by
  // its cycle offset n from E and its tap value.
  bit m_active;
  int m_n;
  int m_T;
  int m_tap;
  int m_cur;
  bit m_err;
  int n_pulse;
  int n_cal;
  int n_rst;
  bit p_prev;
  bit c_prev;
  bit r_prev;

  iodelay_tap_seq #(
    .TAPW     (TW),
    .MAX_TAP  (MAXT),
    .HOLD     (H),
    .GAP      (G),
    .CAL_WAIT (CW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .tap     (tap),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .cal_o   (cal_o),
    .rst_o   (rst_o),
    .pulse_o (pulse_o),
    .cur_tap (cur_tap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare();
    bit e_cal, e_rst, e_pulse, e_busy, e_done;
    int n;
    int k;
    n = m_n;
    e_cal = 0; e_rst = 0; e_pulse = 0; e_busy = 0; e_done = 0;
    if (m_active && n <= m_T) begin
      e_cal   = (n >= 1) && (n <= H);
      e_rst   = (n >= H + CW + 1) && (n <= 2*H + CW);
      e_pulse = (n >= S0) && (n < S0 + m_tap*(H+G)) && (((n - S0) % (H+G)) < H);
      e_busy  = (n >= 1) && (n < m_T);
      e_done  = (n == m_T);
      if (n >= H + CW) begin
        if (n >= S0 + H - 1) begin
          k = (n - (S0 + H - 1)) / (H+G) + 1;
          m_cur = (k < m_tap) ? k : m_tap;
        end else begin
          m_cur = 0;
        end
      end
    end
    check("cal_o",   cal_o,   e_cal);
    check("rst_o",   rst_o,   e_rst);
    check("pulse_o", pulse_o, e_pulse);
    check("busy",    busy,    e_busy);
    check("done",    done,    e_done);
    check("err",     err,     m_err);
    check("cur_tap", int'(cur_tap), m_cur);
    if (pulse_o && !p_prev) n_pulse++;
    if (cal_o && !c_prev)   n_cal++;
    if (rst_o && !r_prev)   n_rst++;
    p_prev = pulse_o; c_prev = cal_o; r_prev = rst_o;
    if (e_done) begin
      check("n_pulse", n_pulse, m_tap);
      check("n_cal",   n_cal,   1);
      check("n_rst",   n_rst,   1);
    end
  endtask

  task automatic step(input bit s, input int t);
    bit idle_before;
    start = s;
    tap   = TW'(t);
    @(posedge clk);
    idle_before = !m_active || (m_n >= m_T);
    m_err = 0;
    if (idle_before && s) begin
      if (t <= MAXT) begin
        m_active = 1;
        m_n      = 0;
        m_tap    = t;
        m_T      = 1 + 2*H + CW + G + t*(H+G);
        n_pulse  = 0;
        n_cal    = 0;
        n_rst    = 0;
      end else begin
        m_err    = 1;
        m_active = 0;
      end
    end else if (m_active) begin
      m_n++;
    end
    #1;
    compare();
  endtask

  task automatic run_to(input int target);
    int lim;
    lim = 0;
    while (m_active && m_n < target && lim < 2000) begin
      step(0, 0);
      lim++;
    end
    if (lim >= 2000) check("run_timeout", lim, 0);
  endtask

  task automatic mid_reset();
    #2;
    reset = 1'b1;
    start = 1'b0;
    m_active = 0;
    m_cur    = 0;
    m_err    = 0;
    #1;
    check("rst_async_pulse", pulse_o, 0);
    check("rst_async_busy",  busy,    0);
    check("rst_async_cur",   int'(cur_tap), 0);
    check("rst_async_cal",   cal_o,   0);
    check("rst_async_rsto",  rst_o,   0);
    p_prev = 0; c_prev = 0; r_prev = 0;
    @(posedge clk);
    #1;
    compare();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int t;
    int gap;
    int cut;
    int lim;
    checks = 0; failures = 0;
    m_active = 0; m_n = 0; m_T = 0; m_tap = 0; m_cur = 0; m_err = 0;
    n_pulse = 0; n_cal = 0; n_rst = 0; p_prev = 0; c_prev = 0; r_prev = 0;
    reset = 1'b1; start = 1'b0; tap = '0;
    #12;
    compare();
    @(negedge clk);
    reset = 1'b0;

    // tap=0: cal and rst only
    step(1, 0);  run_to(m_T);
    step(0, 0);  step(0, 0);
    // tap=3
    step(1, 3);  run_to(m_T);
    step(0, 0);
    // tap=MAX, then a start held into the FIN->IDLE cycle
    step(1, 31); run_to(m_T);
    step(1, 2);  run_to(m_T);
    step(0, 0);
    // out-of-range request
    step(1, 32); step(0, 0); step(0, 0); step(1, 63); step(0, 0);
    // restart during INC_H is ignored
    step(1, 3);  run_to(S0);
    step(1, 7);  step(1, 7);
    run_to(m_T);
    step(0, 0);
    // reset in the middle of INC_H, then a fresh tap=1 command
    step(1, 3);  run_to(S0 + 1);
    mid_reset();
    step(1, 1);  run_to(m_T);
    step(0, 0);

    // randomized commands, restarts while busy and occasional resets
    for (int c = 0; c < 14; c++) begin
      t   = $urandom_range(0, 40);
      gap = $urandom_range(0, 3);
      repeat (gap) step(0, $urandom_range(0, 63));
      step(1, t);
      if (t <= MAXT) begin
        cut = -1;
        if ($urandom_range(0, 4) == 0) cut = $urandom_range(1, m_T - 1);
        lim = 0;
        while (m_active && m_n < m_T && lim < 2000) begin
          if (cut > 0 && m_n == cut) begin
            mid_reset();
            break;
          end
          step(($urandom_range(0, 9) == 0), $urandom_range(0, 63));
          lim++;
        end
        if (lim >= 2000) check("rand_timeout", lim, 0);
      end
    end
    step(0, 0); step(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
